// File: rtl/frame_stepper_if.sv
// Frame stepper signal bundle: frame timing, scroll/animation controls
// and the registered scroll/animation state coming back.
// There is no valid/ready handshake on this bundle. vsync is a level that
// is sampled every clock. The controls (sync_clear, enable, dir, step,
// period, obj_div) are sampled on the cycle a frame edge is seen.
// frame_tick, wrap and step_err are single-cycle pulses. offset,
// obj_frames and frame_count hold until the next update.
interface frame_stepper_if #(
  parameter int OFF_WIDTH  = 20,
  parameter int STEP_WIDTH = 8,
  parameter int N_OBJ      = 5,
  parameter int FRAME_BITS = 3,
  parameter int DIV_BITS   = 3
);
  logic                        vsync;
  logic                        sync_clear;
  logic                        enable;
  logic                        dir;
  logic [STEP_WIDTH-1:0]       step;
  logic [OFF_WIDTH-1:0]        period;
  logic [N_OBJ*DIV_BITS-1:0]   obj_div;
  logic [OFF_WIDTH-1:0]        offset;
  logic [N_OBJ*FRAME_BITS-1:0] obj_frames;
  logic                        frame_tick;
  logic                        wrap;
  logic                        step_err;
  logic [15:0]                 frame_count;

  modport master (
    output vsync, sync_clear, enable, dir, step, period, obj_div,
    input  offset, obj_frames, frame_tick, wrap, step_err, frame_count
  );

  modport slave (
    input  vsync, sync_clear, enable, dir, step, period, obj_div,
    output offset, obj_frames, frame_tick, wrap, step_err, frame_count
  );
endinterface

// File: rtl/frame_stepper.sv
// Per-frame scroll offset stepper with per-object animation dividers.
// A frame edge is a rising vsync level, detected in the clock domain.
// On an enabled edge the offset moves by step and wraps within 0..period.
// Each object's animation frame advances once every obj_div+1 edges.
module frame_stepper #(
  parameter int OFF_WIDTH  = 20,
  parameter int STEP_WIDTH = 8,
  parameter int N_OBJ      = 5,
  parameter int FRAME_BITS = 3,
  parameter int DIV_BITS   = 3
) (
  input logic             clock,
  input logic             reset,
  frame_stepper_if.slave  bus
);
  // One extra bit so that sums and differences never overflow.
  localparam int AW = OFF_WIDTH + 1;

  logic                        prev_vsync;
  logic                        frame_edge;
  logic [OFF_WIDTH-1:0]        offset_q;
  logic [15:0]                 count_q;
  logic                        tick_q;
  logic                        wrap_q;
  logic                        err_q;
  logic [DIV_BITS-1:0]         div_cnt [N_OBJ];
  logic [FRAME_BITS-1:0]       frame_q [N_OBJ];
  logic [N_OBJ*FRAME_BITS-1:0] frames_packed;

  logic [AW-1:0]        off_w;
  logic [AW-1:0]        step_w;
  logic [AW-1:0]        per_w;
  logic [AW-1:0]        sum_w;
  logic [AW-1:0]        tmp_w;
  logic [OFF_WIDTH-1:0] offset_nxt;
  logic                 wrap_nxt;
  logic                 err_nxt;

  // prev_vsync resets to 1, so vsync that is already high after reset
  // does not count as an edge.
  assign frame_edge = bus.vsync & ~prev_vsync;

  // Next offset for an enabled edge. An out-of-range offset takes
  // precedence, then an illegal step, then normal stepping.
  always_comb begin
    off_w      = {1'b0, offset_q};
    step_w     = AW'(bus.step);
    per_w      = {1'b0, bus.period};
    sum_w      = off_w + step_w;
    tmp_w      = '0;
    offset_nxt = offset_q;
    wrap_nxt   = 1'b0;
    err_nxt    = 1'b0;
    if (off_w > per_w) begin
      offset_nxt = '0;
      wrap_nxt   = 1'b1;
    end else if (step_w > per_w) begin
      offset_nxt = '0;
      err_nxt    = 1'b1;
    end else if (!bus.dir) begin
      if (sum_w <= per_w) begin
        offset_nxt = OFF_WIDTH'(sum_w);
      end else begin
        tmp_w      = sum_w - per_w - AW'(1);
        offset_nxt = OFF_WIDTH'(tmp_w);
        wrap_nxt   = 1'b1;
      end
    end else begin
      if (step_w <= off_w) begin
        tmp_w      = off_w - step_w;
      end else begin
        tmp_w      = off_w + per_w + AW'(1) - step_w;
        wrap_nxt   = 1'b1;
      end
      offset_nxt = OFF_WIDTH'(tmp_w);
    end
  end

  // Frame state. sync_clear wins over a simultaneous edge, and the pulses
  // default low every cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_vsync <= 1'b1;
      offset_q   <= '0;
      count_q    <= '0;
      tick_q     <= 1'b0;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < N_OBJ; i++) begin
        div_cnt[i] <= '0;
        frame_q[i] <= '0;
      end
    end else begin
      prev_vsync <= bus.vsync;
      tick_q     <= 1'b0;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
      if (bus.sync_clear) begin
        offset_q <= '0;
        count_q  <= '0;
        for (int i = 0; i < N_OBJ; i++) begin
          div_cnt[i] <= '0;
          frame_q[i] <= '0;
        end
      end else if (frame_edge) begin
        tick_q  <= 1'b1;
        count_q <= count_q + 16'd1;
        if (bus.enable) begin
          offset_q <= offset_nxt;
          wrap_q   <= wrap_nxt;
          err_q    <= err_nxt;
          for (int i = 0; i < N_OBJ; i++) begin
            if (div_cnt[i] >= bus.obj_div[i*DIV_BITS +: DIV_BITS]) begin
              div_cnt[i] <= '0;
              frame_q[i] <= frame_q[i] + FRAME_BITS'(1);
            end else begin
              div_cnt[i] <= div_cnt[i] + DIV_BITS'(1);
            end
          end
        end
      end
    end
  end

  // Pack the per-object frame registers onto the output bus.
  always_comb begin
    frames_packed = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      frames_packed[i*FRAME_BITS +: FRAME_BITS] = frame_q[i];
    end
  end

  assign bus.offset      = offset_q;
  assign bus.obj_frames  = frames_packed;
  assign bus.frame_tick  = tick_q;
  assign bus.wrap        = wrap_q;
  assign bus.step_err    = err_q;
  assign bus.frame_count = count_q;
endmodule

// File: tb/tb_frame_stepper.sv
// Directed bench for frame_stepper. A behavioural model predicts each
// frame's result. The prediction is queued when the vsync pulse is driven
// and compared when frame_tick appears.
module tb_frame_stepper;
  localparam int OW = 20;
  localparam int NO = 5;
  localparam int FB = 3;
  localparam int DB = 3;
  localparam int W  = 2 + OW + 16 + NO*FB;

  // Clock and reset.
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  frame_stepper_if sif ();

  frame_stepper dut (
    .clock (clock),
    .reset (reset),
    .bus   (sif)
  );

  // Scoreboard and model state.
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int m_off, m_cnt;
  bit m_wrap, m_err;
  int m_div[NO];
  int m_frm[NO];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_off = 0; m_cnt = 0; m_wrap = 0; m_err = 0;
    for (int i = 0; i < NO; i++) begin
      m_div[i] = 0;
      m_frm[i] = 0;
    end
  endtask

  // Behavioural prediction of one frame edge, using the current inputs.
  task automatic model_edge();
    int p, s, n, d;
    m_cnt  = (m_cnt + 1) % 65536;
    m_wrap = 0;
    m_err  = 0;
    if (sif.enable) begin
      p = int'(sif.period);
      s = int'(sif.step);
      if (m_off > p) begin
        m_off = 0; m_wrap = 1;
      end else if (s > p) begin
        m_off = 0; m_err = 1;
      end else if (!sif.dir) begin
        n = m_off + s;
        m_wrap = (n > p);
        m_off = n % (p + 1);
      end else begin
        n = m_off - s;
        if (n < 0) begin
          n = n + p + 1;
          m_wrap = 1;
        end
        m_off = n;
      end
      for (int i = 0; i < NO; i++) begin
        d = int'((sif.obj_div >> (i*DB)) & 15'h7);
        if (m_div[i] >= d) begin
          m_div[i] = 0;
          m_frm[i] = (m_frm[i] + 1) % 8;
        end else begin
          m_div[i] = m_div[i] + 1;
        end
      end
    end
  endtask

  function automatic logic [W-1:0] pack_exp();
    logic [NO*FB-1:0] f;
    f = '0;
    for (int i = 0; i < NO; i++) f[i*FB +: FB] = FB'(m_frm[i]);
    return {m_wrap, m_err, OW'(m_off), 16'(m_cnt), f};
  endfunction

  // Driver: one vsync pulse, then compare the popped prediction.
  task automatic do_frame(input string tag);
    logic [W-1:0] e;
    bit got;
    got = 1'b0;
    model_edge();
    exp_q.push_back(pack_exp());
    @(negedge clock) sif.vsync = 1'b1;
    for (int c = 0; c < 4 && !got; c++) begin
      @(negedge clock);
      got = sif.frame_tick;
    end
    sif.vsync = 1'b0;
    e = exp_q.pop_front();
    check({tag, "_tick"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, "_wrap"},   32'(sif.wrap),        32'(e[W-1]));
      check({tag, "_err"},    32'(sif.step_err),    32'(e[W-2]));
      check({tag, "_off"},    32'(sif.offset),      32'(e[W-3 -: OW]));
      check({tag, "_count"},  32'(sif.frame_count), 32'(e[NO*FB +: 16]));
      check({tag, "_frames"}, 32'(sif.obj_frames),  32'(e[NO*FB-1:0]));
    end
  endtask

  task automatic count_ticks(input int n, output int k);
    k = 0;
    repeat (n) begin
      @(negedge clock);
      if (sif.frame_tick) k++;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_off"},    32'(sif.offset),      32'd0);
    check({tag, "_frames"}, 32'(sif.obj_frames),  32'd0);
    check({tag, "_count"},  32'(sif.frame_count), 32'd0);
    check({tag, "_tick"},   32'(sif.frame_tick),  32'd0);
    check({tag, "_wrap"},   32'(sif.wrap),        32'd0);
    check({tag, "_err"},    32'(sif.step_err),    32'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Directed sequence.
  initial begin
    int k;
    reset = 1'b0;
    sif.vsync = 1'b1; sif.sync_clear = 1'b0; sif.enable = 1'b0; sif.dir = 1'b0;
    sif.step = '0; sif.period = '0; sif.obj_div = '0;
    model_clear();
    repeat (3) @(negedge clock);
    check_zero("reset");

    // Release with vsync already high: no edge until it toggles.
    reset = 1'b1;
    count_ticks(5, k);
    check("rel_no_tick", 32'(k), 32'd0);
    sif.vsync = 1'b0;
    @(negedge clock);

    // Ascending scroll through a full 768-position period.
    sif.period = 20'd767; sif.step = 8'd1; sif.dir = 1'b0; sif.enable = 1'b1;
    for (int i = 0; i < 768; i++) begin
      do_frame("s1");
      if (i == 766) check("s1_top", 32'(sif.offset), 32'd767);
    end
    check("s1_wrap_off", 32'(sif.offset), 32'd0);
    check("s1_wrap", 32'(sif.wrap), 32'd1);
    @(negedge clock);
    check("s1_wrap_pulse", 32'(sif.wrap), 32'd0);
    check("s1_tick_pulse", 32'(sif.frame_tick), 32'd0);

    // Descending scroll with underflow wrap.
    sif.period = 20'd100; sif.step = 8'd10;
    do_frame("s2a");
    check("s2_start", 32'(sif.offset), 32'd10);
    sif.step = 8'd30; sif.dir = 1'b1;
    do_frame("s2b");
    check("s2_off81", 32'(sif.offset), 32'd81);
    check("s2_wrap1", 32'(sif.wrap), 32'd1);
    do_frame("s2c");
    check("s2_off51", 32'(sif.offset), 32'd51);
    check("s2_wrap0", 32'(sif.wrap), 32'd0);

    // sync_clear, then animation dividers; step=0 holds the offset.
    @(negedge clock) sif.sync_clear = 1'b1;
    @(negedge clock) sif.sync_clear = 1'b0;
    model_clear();
    check_zero("clear");
    sif.obj_div = {3'd2, 3'd1, 3'd7, 3'd3, 3'd0};
    sif.period = 20'd1000; sif.step = 8'd0; sif.dir = 1'b0;
    for (int i = 0; i < 8; i++) do_frame("s4");
    check("s4_obj0", 32'(sif.obj_frames[2:0]), 32'd0);
    check("s4_obj1", 32'(sif.obj_frames[5:3]), 32'd2);
    check("s4_hold", 32'(sif.offset), 32'd0);
    sif.enable = 1'b0;
    for (int i = 0; i < 4; i++) do_frame("s4d");
    check("s4d_obj1", 32'(sif.obj_frames[5:3]), 32'd2);
    check("s4d_count", 32'(sif.frame_count), 32'd12);

    // Period lowered below the current offset.
    sif.enable = 1'b1; sif.step = 8'd250;
    do_frame("s5a");
    do_frame("s5b");
    check("s5_500", 32'(sif.offset), 32'd500);
    sif.period = 20'd200; sif.step = 8'd5;
    do_frame("s5c");
    check("s5_off0", 32'(sif.offset), 32'd0);
    check("s5_wrap", 32'(sif.wrap), 32'd1);

    // Step larger than period, then vsync held high.
    sif.period = 20'd40; sif.step = 8'd50;
    do_frame("s6");
    check("s6_err", 32'(sif.step_err), 32'd1);
    check("s6_nowrap", 32'(sif.wrap), 32'd0);
    @(negedge clock);
    check("s6_err_pulse", 32'(sif.step_err), 32'd0);
    model_edge();
    sif.vsync = 1'b1;
    count_ticks(100, k);
    sif.vsync = 1'b0;
    check("s6_held_ticks", 32'(k), 32'd1);
    check("s6_held_count", 32'(sif.frame_count), 32'(m_cnt));
    @(negedge clock);

    // Reset asserted mid-frame with vsync high.
    sif.period = 20'd100; sif.step = 8'd7;
    do_frame("s7a");
    @(negedge clock) sif.vsync = 1'b1;
    #2 reset = 1'b0;
    #1 check("s7_async_off", 32'(sif.offset), 32'd0);
    model_clear();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    count_ticks(5, k);
    check("s7_no_tick", 32'(k), 32'd0);
    check_zero("s7_rel");
    sif.vsync = 1'b0;
    @(negedge clock);
    do_frame("s7b");
    check("s7_resume", 32'(sif.offset), 32'd7);

    // sync_clear coincident with an edge.
    do_frame("s8a");
    @(negedge clock);
    sif.vsync = 1'b1; sif.sync_clear = 1'b1;
    @(negedge clock);
    check_zero("s8_clr");
    sif.sync_clear = 1'b0;
    model_clear();
    @(negedge clock);
    check("s8_lost", 32'(sif.frame_tick), 32'd0);
    sif.vsync = 1'b0;
    @(negedge clock);
    do_frame("s8b");

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_stepper.md
FRAME_STEPPER -- requirements
Module: frame_stepper

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- OFF_WIDTH, 20, scroll offset and period width.
- STEP_WIDTH, 8, per-frame step width.
- N_OBJ, 5, number of animated objects.
- FRAME_BITS, 3, animation frame index width per object.
- DIV_BITS, 3, per-object frame divider width.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Ports, one per line: name, direction, width, meaning.
- clock, in, 1, system clock (65 MHz pixel clock).
- reset, in, 1, asynchronous, active-low reset.
- vsync, in, 1, active-high vertical sync level, synchronous to clock.
- sync_clear, in, 1, synchronous clear.
- enable, in, 1, 1 = advance offset and animations on each frame.
- dir, in, 1, 0 = offset increases, 1 = offset decreases.
- step, in, STEP_WIDTH, offset increment per frame.
- period, in, OFF_WIDTH, offset wraps within the range 0..period inclusive.
- obj_div, in, N_OBJ*DIV_BITS, per-object divider; object i occupies bits [i*DIV_BITS +: DIV_BITS].
- offset, out, OFF_WIDTH, current scroll offset.
- obj_frames, out, N_OBJ*FRAME_BITS, per-object animation frame, packed the same way as obj_div.
- frame_tick, out, 1, one-cycle pulse per detected frame.
- wrap, out, 1, one-cycle pulse when offset wraps.
- step_err, out, 1, one-cycle pulse when step > period.
- frame_count, out, 16, total frames detected.

Function
REQ-004 A frame edge SHALL occur in a cycle where vsync=1 and the registered previous vsync=0.
- All vsync-driven logic SHALL be clocked by clock only; vsync SHALL NOT be used as a clock.
REQ-005 On the clock edge ending a frame-edge cycle, the block SHALL register the following, so all are visible one cycle after vsync is first sampled high:
- frame_tick=1
- frame_count+1, wrapping at 16'hFFFF to 0
- offset, obj_frames, wrap and step_err updates
REQ-006 frame_tick, wrap and step_err SHALL be high for exactly one cycle.
REQ-007 With enable=1 and dir=0 at a frame edge:
- if offset+step <= period, offset <= offset+step;
- else offset <= offset+step-(period+1) and wrap=1.
- All arithmetic SHALL be done at OFF_WIDTH+1 bits.
REQ-008 With enable=1 and dir=1 at a frame edge:
- if step <= offset, offset <= offset-step;
- else offset <= offset+(period+1)-step and wrap=1.
REQ-009 If step > period at an enabled frame edge, offset <= 0, step_err=1 and wrap=0.
REQ-010 If offset > period at a frame edge (period lowered mid-run), offset <= 0 and wrap=1. This rule SHALL take priority over REQ-007 and REQ-008.
REQ-011 step=0 SHALL hold offset with no wrap.
REQ-012 Each object i SHALL keep a DIV_BITS divider counter. At an enabled frame edge:
- if div_cnt >= obj_div[i], div_cnt <= 0 and frame[i] <= frame[i]+1, wrapping modulo 2^FRAME_BITS;
- else div_cnt <= div_cnt+1.
REQ-013 As a result, obj_div=0 SHALL advance the object every frame, and obj_div=d SHALL advance it every d+1 frames.
- The >= comparison covers obj_div being lowered below the current div_cnt.
REQ-014 With enable=0 at a frame edge:
- frame_tick and frame_count SHALL still update;
- offset, div counters, obj_frames, wrap and step_err SHALL hold.
REQ-015 sync_clear=1 SHALL zero offset, all div counters, obj_frames and frame_count on the next edge, and SHALL suppress all pulses.
- It SHALL take priority over a simultaneous frame edge; that edge is lost.
REQ-016 vsync held high SHALL produce exactly one frame edge.
REQ-017 offset, obj_frames and frame_count SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-018 reset=0 SHALL asynchronously force the following, whatever the clock is doing:
- offset, obj_frames, frame_count, div counters = 0
- frame_tick, wrap, step_err = 0
- previous-vsync register = 1
REQ-019 Because the previous-vsync register resets to 1, vsync already high at reset release SHALL NOT produce a frame edge; the first edge SHALL require vsync to go low then high.
REQ-020 Reset asserted mid-frame SHALL discard any pending edge.
- Operation SHALL resume from zero on the first clock edge after release.

Verification
REQ-021 The bench SHALL cover these directed scenarios (stimulus -> required response):
- period=767, step=1, dir=0, enable=1, 768 vsync pulses -> offset steps 0..767, and pulse 768 gives offset=0 with wrap=1.
- period=100, step=30, dir=1, offset=10 -> next frame offset=81, wrap=1; next frame offset=51, wrap=0.
- obj_div for object 0 = 0 and object 1 = 3, 8 frames -> obj0 frame=0 (8 advances wrap modulo 8), obj1 frame=2; with enable=0 for 4 frames -> no change, frame_count still +4.
- offset=500, period lowered to 200, then frame edge -> offset=0, wrap=1.
- step=50, period=40 -> offset=0, step_err=1 for one cycle; vsync held high 100 cycles -> frame_count +1 only.
- reset=0 mid-frame with vsync=1, release while vsync=1 -> no frame_tick until vsync 0->1; sync_clear coincident with an edge -> all zero, no frame_tick.
